ecg_sample_window_buffer: RTL and testbench
===========================================

# ecg_sample_window_buffer

Downstream consumer of the UART number parser's output. Collects signed ECG samples, delivered as `Valid_num` / `Data_out` pulses, into fixed-length windows for the classifier. Ping-pong storage lets one window fill while the classifier reads the other. Samples that arrive while both windows are occupied are dropped and counted.

## Interface
Parameters:
- `DATA_WIDTH`, 16: sample width, two's complement; matches parser output width.
- `WINDOW_LEN`, 187: samples per window (one heartbeat segment).
- `ADDR_WIDTH`, 8: read address width; must satisfy 2^ADDR_WIDTH >= WINDOW_LEN.

Ports:
- `Clk`  in  1  rising-edge clock, same domain as the parser.
- `Rst`  in  1  asynchronous, active-high reset.
- `Sample_valid`  in  1  one-cycle strobe; connect to parser `Valid_num`.
- `Sample_in`  in  DATA_WIDTH  signed sample; connect to parser `Data_out`.
- `Window_ready`  out  1  level; a complete window is available in the read bank.
- `Rd_addr`  in  ADDR_WIDTH  sample index within the read bank.
- `Rd_data`  out  DATA_WIDTH  registered read data.
- `Window_release`  in  1  one-cycle strobe; the classifier has finished with the read bank.
- `Fill_level`  out  ADDR_WIDTH  number of samples written so far into the current write bank.
- `Drop_count`  out  16  saturating count of dropped samples.

## Operation
- Storage: two banks of WINDOW_LEN x DATA_WIDTH, each with a `full` flag.
- Pointers: `wr_bank`, `rd_bank` (1 bit each), and `wr_ptr`, which drives `Fill_level`.
- Write path, on `Sample_valid`:
  - If `full[wr_bank]` is set, the sample is dropped. `Drop_count` increments and holds at 0xFFFF.
  - Otherwise `Sample_in` is stored at `mem[wr_bank][wr_ptr]`.
  - If `wr_ptr == WINDOW_LEN-1`: set `full[wr_bank]`, clear `wr_ptr`, toggle `wr_bank`.
  - Else: increment `wr_ptr`.
- Read path: `Window_ready = full[rd_bank]`, decoded from registered state only.
- Every cycle, `Rd_data` is loaded from `mem[rd_bank][Rd_addr]`. This happens regardless of `Window_ready`.
- `Rd_addr >= WINDOW_LEN` loads 0.
- Release: `Window_release` while `Window_ready = 1` clears `full[rd_bank]` and toggles `rd_bank`.
- `Window_release` while `Window_ready = 0` is ignored.
- Windows are delivered strictly in fill order; a window is never overwritten before it is released.
- Sample values are stored verbatim. No sign extension, clipping or arithmetic is applied.
- Bank states per bank: EMPTY -> FILLING (`wr_bank` points at it) -> FULL -> (release) EMPTY.

## Timing
- Reset (async assert, sync-safe deassert):
  - `wr_ptr`, `wr_bank`, `rd_bank` = 0.
  - Both `full` flags = 0.
  - `Window_ready`, `Rd_data`, `Fill_level`, `Drop_count` = 0.
  - Memory contents are not reset.
- Reset mid-window discards all partial and full windows. The first sample after reset goes to bank 0, address 0.
- Write completes at the edge where `Sample_valid` is sampled high. `Fill_level` updates the same edge.
- `Window_ready` rises in the cycle after the edge that writes sample WINDOW_LEN-1.
- `Rd_data` has one-cycle latency: the address presented before edge k appears after edge k.
- A write and a read of the same bank/address in the same cycle return the old data. This only occurs if the consumer reads a non-ready bank.
- Release takes effect at its edge:
  - The read issued on that same edge still uses the old `rd_bank`.
  - `Window_ready` drops the next cycle, unless the other bank is already full. In that case it stays high and now refers to the other bank.
- Simultaneous release and `Sample_valid` when both banks are full: the drop decision uses pre-edge flags. The sample is dropped and `Drop_count` increments. The next sample lands at address 0 of the freed bank.
- Simultaneous release and write-completion on opposite banks are independent; both take effect.
- Sustained input of one sample per cycle is supported with no bubbles.

## Test plan
- **Single window.** Stimulus: reset, then 187 strobes with value i-93 (i = 0..186). Required response:
  - `Window_ready` = 1 exactly one cycle after the last strobe.
  - `Rd_addr` 0 -> `Rd_data` 0xFFA3.
  - `Rd_addr` 186 -> `Rd_data` 0x005D.
  - `Fill_level` = 0.
- **Overflow.** Stimulus: hold bank 0 unreleased and send 188 more samples. Required response:
  - Bank 1 fills.
  - The 188th sample is dropped; `Drop_count` = 1.
  - `Window_ready` stays 1.
- **Release with both banks full.** Stimulus: pulse `Window_release`. Required response:
  - `Window_ready` stays 1.
  - `Rd_addr` 0 returns bank 1's first sample.
  - A following sample is written to bank 0, address 0; `Fill_level` = 1.
- **Simultaneous release and sample.** Stimulus: both banks full; `Window_release` and `Sample_valid` (value 0x1234) on the same edge. Required response:
  - Sample dropped; `Drop_count` increments.
  - The next sample, 0x0042, is readable at address 0 of the freed bank after that bank fills.
- **Async reset mid-window.** Stimulus: send 50 samples, assert `Rst` mid-cycle. Required response:
  - All outputs read 0 before the next edge.
  - After deassert, 187 new samples produce `Window_ready` with address 0 holding the first post-reset sample.
- **Spurious release and out-of-range read.** Stimulus: `Window_release` with `Window_ready` = 0; `Rd_addr` = 200. Required response:
  - State unchanged; `Rd_data` = 0.
- **Drop counter saturation.** Stimulus: with `WINDOW_LEN` = 4, 70000 drops. Required response:
  - `Drop_count` holds at 0xFFFF.

Source files
------------

// File: rtl/ecg_sample_window_buffer.sv
// Ping-pong window buffer for parsed ECG samples. One bank fills while the other
// is read by the classifier. Samples arriving while both banks are full are dropped and counted.
module ecg_sample_window_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int WINDOW_LEN = 187,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Sample_valid,
  input  logic [DATA_WIDTH-1:0] Sample_in,
  output logic                  Window_ready,
  input  logic [ADDR_WIDTH-1:0] Rd_addr,
  output logic [DATA_WIDTH-1:0] Rd_data,
  input  logic                  Window_release,
  output logic [ADDR_WIDTH-1:0] Fill_level,
  output logic [15:0]           Drop_count
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(WINDOW_LEN - 1);

  logic [DATA_WIDTH-1:0] r_mem [2][WINDOW_LEN];
  logic [1:0]            r_full;
  logic                  r_wr_bank;
  logic                  r_rd_bank;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [15:0]           r_drop_count;
  logic [DATA_WIDTH-1:0] r_rd_data;

  logic w_accept;
  logic w_drop;
  logic w_release;
  logic w_last;
  logic w_rd_in_range;

  assign w_accept      = Sample_valid & ~r_full[r_wr_bank];
  assign w_drop        = Sample_valid &  r_full[r_wr_bank];
  assign w_release     = Window_release & r_full[r_rd_bank];
  assign w_last        = (r_wr_ptr == LAST_IDX);
  assign w_rd_in_range = (Rd_addr <= LAST_IDX);

  assign Window_ready = r_full[r_rd_bank];
  assign Rd_data      = r_rd_data;
  assign Fill_level   = r_wr_ptr;
  assign Drop_count   = r_drop_count;

  // Storage has no reset; the full flags alone say what is valid.
  always_ff @(posedge Clk) begin
    if (w_accept) begin
      r_mem[r_wr_bank][r_wr_ptr] <= Sample_in;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_rd_data <= '0;
    end else if (w_rd_in_range) begin
      r_rd_data <= r_mem[r_rd_bank][Rd_addr];
    end else begin
      r_rd_data <= '0;
    end
  end

  // A release only targets a full bank and a completing write only targets a
  // non-full bank, so the two flag updates never hit the same bit.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_full       <= 2'b00;
      r_wr_bank    <= 1'b0;
      r_rd_bank    <= 1'b0;
      r_wr_ptr     <= '0;
      r_drop_count <= '0;
    end else begin
      if (w_release) begin
        r_full[r_rd_bank] <= 1'b0;
        r_rd_bank         <= ~r_rd_bank;
      end
      if (w_accept) begin
        if (w_last) begin
          r_full[r_wr_bank] <= 1'b1;
          r_wr_ptr          <= '0;
          r_wr_bank         <= ~r_wr_bank;
        end else begin
          r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
        end
      end
      if (w_drop && (r_drop_count != 16'hFFFF)) begin
        r_drop_count <= r_drop_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_ecg_sample_window_buffer.sv
// Directed bench for ecg_sample_window_buffer: a queue-based window model checked every
// cycle, hand-computed literal checks, and a small-window instance for drop saturation.
module tb_ecg_sample_window_buffer;
  localparam int WL = 187;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Sample_valid = 1'b0;
  logic [15:0] Sample_in = '0;
  logic        Window_ready;
  logic [7:0]  Rd_addr = '0;
  logic [15:0] Rd_data;
  logic        Window_release = 1'b0;
  logic [7:0]  Fill_level;
  logic [15:0] Drop_count;

  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_rd_data;
  logic [1:0]  s_fill;
  logic [15:0] s_drop;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 Clk = ~Clk;

  ecg_sample_window_buffer #(.DATA_WIDTH(16), .WINDOW_LEN(WL), .ADDR_WIDTH(8)) dut (
    .Clk(Clk), .Rst(Rst), .Sample_valid(Sample_valid), .Sample_in(Sample_in),
    .Window_ready(Window_ready), .Rd_addr(Rd_addr), .Rd_data(Rd_data),
    .Window_release(Window_release), .Fill_level(Fill_level), .Drop_count(Drop_count)
  );

  ecg_sample_window_buffer #(.DATA_WIDTH(16), .WINDOW_LEN(4), .ADDR_WIDTH(2)) dut_sat (
    .Clk(Clk), .Rst(Rst), .Sample_valid(s_valid), .Sample_in(16'h0055),
    .Window_ready(s_ready), .Rd_addr(2'd0), .Rd_data(s_rd_data),
    .Window_release(1'b0), .Fill_level(s_fill), .Drop_count(s_drop)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: completed windows are concatenated in fill order; front WL entries are the read window.
  logic [15:0] done_q[$];
  logic [15:0] cur_q[$];
  int          m_drop = 0;
  logic [15:0] exp_rd = '0;
  bit          exp_rd_ok = 1'b0;

  always @(posedge Clk or posedge Rst) begin
    int nfull;
    if (Rst) begin
      done_q.delete();
      cur_q.delete();
      m_drop    = 0;
      exp_rd    = '0;
      exp_rd_ok = 1'b1;
    end else begin
      nfull = done_q.size() / WL;
      if (Rd_addr >= WL) begin
        exp_rd = '0; exp_rd_ok = 1'b1;
      end else if (nfull > 0) begin
        exp_rd = done_q[Rd_addr]; exp_rd_ok = 1'b1;
      end else begin
        exp_rd_ok = 1'b0;
      end
      if (Sample_valid && nfull == 2) begin
        if (m_drop < 65535) m_drop++;
      end else if (Sample_valid) begin
        cur_q.push_back(Sample_in);
        if (cur_q.size() == WL) begin
          done_q = {done_q, cur_q};
          cur_q.delete();
        end
      end
      if (Window_release && nfull > 0)
        repeat (WL) void'(done_q.pop_front());
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      check("m_ready", Window_ready, (done_q.size() >= WL));
      check("m_fill", Fill_level, cur_q.size());
      check("m_drop", Drop_count, m_drop);
      if (exp_rd_ok) check("m_rd_data", Rd_data, exp_rd);
    end
  end

  task automatic send(input logic [15:0] v);
    Sample_valid = 1'b1;
    Sample_in    = v;
    @(posedge Clk); #1;
    Sample_valid = 1'b0;
  endtask

  task automatic release_pulse();
    Window_release = 1'b1;
    @(posedge Clk); #1;
    Window_release = 1'b0;
  endtask

  task automatic read_at(input logic [7:0] a);
    Rd_addr = a;
    @(posedge Clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge Clk);
    #1;
    check("rst_ready", Window_ready, 0);
    check("rst_fill", Fill_level, 0);
    check("rst_drop", Drop_count, 0);
    check("rst_rd_data", Rd_data, 0);
    Rst = 1'b0;
    chk_en = 1'b1;
    @(posedge Clk); #1;

    // Single window
    for (int i = 0; i < WL; i++) send(16'(i - 93));
    check("win1_ready", Window_ready, 1);
    check("win1_fill", Fill_level, 0);
    read_at(8'd0);
    check("win1_rd0", Rd_data, 16'hFFA3);
    read_at(8'd186);
    check("win1_rd186", Rd_data, 16'h005D);

    // Overflow: bank 1 fills, 188th sample dropped
    for (int i = 0; i < WL + 1; i++) send(16'h1000 + 16'(i));
    check("ovf_drop", Drop_count, 1);
    check("ovf_ready", Window_ready, 1);
    check("ovf_fill", Fill_level, 0);
    read_at(8'd0);
    check("ovf_rd0_bank0", Rd_data, 16'hFFA3);

    // Release with both full
    release_pulse();
    check("rel_ready", Window_ready, 1);
    read_at(8'd0);
    check("rel_rd0_bank1", Rd_data, 16'h1000);
    send(16'h0777);
    check("rel_fill", Fill_level, 1);

    // Simultaneous release and sample with both banks full
    for (int i = 0; i < WL - 1; i++) send(16'h3000 + 16'(i));
    check("sim_pre_drop", Drop_count, 1);
    Window_release = 1'b1;
    send(16'h1234);
    Window_release = 1'b0;
    check("sim_drop", Drop_count, 2);
    check("sim_ready", Window_ready, 1);
    check("sim_fill", Fill_level, 0);
    read_at(8'd0);
    check("sim_rd0_bank0", Rd_data, 16'h0777);
    send(16'h0042);
    for (int i = 0; i < WL - 1; i++) send(16'h4000 + 16'(i));
    release_pulse();
    check("sim_ready2", Window_ready, 1);
    read_at(8'd0);
    check("sim_rd0_0042", Rd_data, 16'h0042);

    // Spurious release and out-of-range read
    release_pulse();
    check("spur_ready_low", Window_ready, 0);
    release_pulse();
    check("spur_ready", Window_ready, 0);
    check("spur_fill", Fill_level, 0);
    check("spur_drop", Drop_count, 2);
    read_at(8'd200);
    check("oor_rd_data", Rd_data, 0);
    read_at(8'd187);
    check("oor_rd_187", Rd_data, 0);

    // Async reset mid-window
    Rd_addr = 8'd0;
    for (int i = 0; i < 50; i++) send(16'h5000 + 16'(i));
    check("pre_rst_fill", Fill_level, 50);
    #2 Rst = 1'b1;
    #1;
    check("arst_ready", Window_ready, 0);
    check("arst_fill", Fill_level, 0);
    check("arst_drop", Drop_count, 0);
    check("arst_rd_data", Rd_data, 0);
    @(posedge Clk); #3;
    Rst = 1'b0;
    @(posedge Clk); #1;
    for (int i = 0; i < WL; i++) send(16'h2000 + 16'(i));
    check("post_rst_ready", Window_ready, 1);
    check("post_rst_fill", Fill_level, 0);
    read_at(8'd0);
    check("post_rst_rd0", Rd_data, 16'h2000);
    read_at(8'd1);
    check("post_rst_rd1", Rd_data, 16'h2001);

    // Drop saturation on the 4-sample instance: 8 accepted, then drops
    check("sat_start", s_drop, 0);
    s_valid = 1'b1;
    repeat (8 + 65534) @(posedge Clk);
    #1;
    check("sat_ready", s_ready, 1);
    check("sat_65534", s_drop, 16'hFFFE);
    @(posedge Clk); #1;
    check("sat_65535", s_drop, 16'hFFFF);
    repeat (70000 - 65535) @(posedge Clk);
    #1;
    s_valid = 1'b0;
    check("sat_70000", s_drop, 16'hFFFF);
    check("sat_fill", s_fill, 0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
